// File: rtl/uart_pkg.sv
// Shared definitions for the UART slice.
//   - Default clock rate, line rate and derived cycles-per-bit.
//   - Receiver state enumeration used by uart_rx.
package uart_pkg;

    localparam int unsigned ClkHzDefault      = 12_000_000;
    localparam int unsigned BaudDefault       = 115_200;
    localparam int unsigned ClksPerBitDefault = ClkHzDefault / BaudDefault;  // 104

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitIdle
    } rx_state_e;

endpackage

// File: rtl/uart_if.sv
// Byte-level host interface of the UART.
//   tx_byte        : byte to transmit (host -> uart)
//   send_request   : transmit request, sampled every cycle (host -> uart)
//   busy           : transmit frame in progress (uart -> host)
//   rx_byte        : last correctly received byte (uart -> host)
//   byte_available : one-cycle pulse when rx_byte updates (uart -> host)
interface uart_if;

    logic [7:0] tx_byte;
    logic       send_request;
    logic       busy;
    logic [7:0] rx_byte;
    logic       byte_available;

    // Host side.
    modport master (
        output tx_byte,
        output send_request,
        input  busy,
        input  rx_byte,
        input  byte_available
    );

    // UART side.
    modport slave (
        input  tx_byte,
        input  send_request,
        output busy,
        output rx_byte,
        output byte_available
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver.
//   clk, rst_n       : clock, synchronous active-low reset
//   rx_i             : asynchronous serial line, idle high
//   rx_byte_o        : last correctly framed byte, held between pulses
//   byte_available_o : one-cycle pulse when rx_byte_o is updated
// CLKS_PER_BIT must be at least 2.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_available_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      rx_byte_q;
    logic            avail_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Synchronizer resets to the idle level so reset release is not seen as a start edge.
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RxIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_byte_q <= '0;
            avail_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            avail_q   <= 1'b0;
            unique case (state_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RxStart;
                        cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (cnt_q == HalfM1) begin
                        // Line back high at mid start bit: glitch, drop it.
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (cnt_q == FullM1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_q <= RxStop;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (cnt_q == FullM1) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            rx_byte_q <= shift_q;
                            avail_q   <= 1'b1;
                            state_q   <= RxIdle;
                        end else begin
                            state_q <= RxWaitIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxWaitIdle: begin
                    if (rx_sync_q) begin
                        state_q <= RxIdle;
                    end
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

    assign rx_byte_o        = rx_byte_q;
    assign byte_available_o = avail_q;

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: inline transmitter plus uart_rx receiver.
//   clk, rst_n : clock, synchronous active-low reset
//   rx         : asynchronous serial receive line, idle high
//   tx         : serial transmit line, idle high
//   bus        : host byte interface (tx_byte, send_request, busy, rx_byte, byte_available)
module uart
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = ClkHzDefault,
    parameter int unsigned BAUD         = BaudDefault,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    rx,
    output logic    tx,
    uart_if.slave   bus
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

    logic            tx_q, busy_q;
    logic [CntW-1:0] tx_cnt_q;
    logic [3:0]      tx_idx_q;
    logic [8:0]      tx_shift_q;  // remaining data bits plus stop bit
    logic            frame_end, start;

    // A request seen on the final edge of a frame starts the next frame directly, so
    // back-to-back frames have no idle gap and busy stays high across them.
    assign frame_end = busy_q && (tx_cnt_q == FullM1) && (tx_idx_q == 4'd9);
    assign start     = bus.send_request && (!busy_q || frame_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '1;
        end else if (start) begin
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= {1'b1, bus.tx_byte};
        end else if (busy_q) begin
            if (tx_cnt_q == FullM1) begin
                tx_cnt_q <= '0;
                if (tx_idx_q == 4'd9) begin
                    busy_q <= 1'b0;
                    tx_q   <= 1'b1;
                end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_idx_q   <= tx_idx_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    assign tx       = tx_q;
    assign bus.busy = busy_q;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_i            (rx),
        .rx_byte_o       (bus.rx_byte),
        .byte_available_o(bus.byte_available)
    );

endmodule

// File: tb/tb_uart.sv
// Directed self-checking bench for uart: reset, transmit timing, busy rejection,
// reset abort, receive, glitch and framing errors, and back-to-back loopback.
module tb_uart;

    localparam int unsigned CPB = 104;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rx_drv  = 1'b1;
    logic loop_en = 1'b0;
    logic rx;
    logic tx;

    int tests = 0;
    int fails = 0;

    uart_if bus ();

    assign rx = loop_en ? tx : rx_drv;

    uart #(
        .CLK_HZ      (12_000_000),
        .BAUD        (115_200),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .tx   (tx),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame on rx, then tail idle cycles; report pulses, last pulse cycle and value.
    task automatic send_rx(input logic [7:0] b, input logic stop, input int tail,
                           output int npulse, output int at, output logic [7:0] val);
        logic [9:0] fr;
        fr     = {stop, b, 1'b0};
        npulse = 0;
        at     = -1;
        val    = 8'h00;
        for (int i = 0; i < 10 * CPB + tail; i++) begin
            rx_drv = (i < 10 * CPB) ? fr[i / CPB] : 1'b1;
            tick();
            if (bus.byte_available) begin
                npulse++;
                at  = i;
                val = bus.rx_byte;
            end
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int         np;
        int         at;
        logic [7:0] val;
        logic       flag;
        logic       flag2;
        logic [9:0] fr;
        logic [7:0] got[3];

        bus.tx_byte      = 8'h00;
        bus.send_request = 1'b0;

        // Reset held for two edges.
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset tx", tx, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset byte_available", bus.byte_available, 0);
        chk("reset rx_byte", bus.rx_byte, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Transmit 0xA5; a 0x11 request mid-frame must be ignored.
        fr               = {1'b1, 8'hA5, 1'b0};
        bus.tx_byte      = 8'hA5;
        bus.send_request = 1'b1;
        tick();
        bus.send_request = 1'b0;
        flag  = 1'b0;
        flag2 = 1'b0;
        for (int j = 0; j < 1100; j++) begin
            if (j < 1040 && (j % CPB) == 0)
                chk($sformatf("tx A5 bit%0d first", j / CPB), tx, fr[j / CPB]);
            if (j < 1040 && (j % CPB) == CPB - 1)
                chk($sformatf("tx A5 bit%0d last", j / CPB), tx, fr[j / CPB]);
            if (j < 1040 && !bus.busy) flag = 1'b1;
            if (j >= 1040 && (bus.busy || !tx)) flag2 = 1'b1;
            if (j == 1040) begin
                chk("busy falls after 1040", bus.busy, 0);
                chk("tx idle after frame", tx, 1);
            end
            if (j == 300) begin
                bus.tx_byte      = 8'h11;
                bus.send_request = 1'b1;
            end
            if (j == 301) bus.send_request = 1'b0;
            tick();
        end
        chk("busy held whole frame", flag, 0);
        chk("rejected request not queued", flag2, 0);

        // Reset mid-frame aborts the transmitter.
        bus.tx_byte      = 8'hF0;
        bus.send_request = 1'b1;
        tick();
        bus.send_request = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        chk("mid-frame tx low", tx, 0);
        rst_n = 1'b0;
        tick();
        chk("abort tx", tx, 1);
        chk("abort busy", bus.busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Receive 0x3C.
        send_rx(8'h3C, 1'b1, 20, np, at, val);
        chk("rx 3C pulses", np, 1);
        chk("rx 3C value", val, 8'h3C);
        chk("rx 3C in stop bit", (at >= 9 * CPB) && (at < 10 * CPB), 1);
        chk("rx_byte held", bus.rx_byte, 8'h3C);

        // 30-cycle glitch.
        np     = 0;
        rx_drv = 1'b0;
        for (int i = 0; i < 330; i++) begin
            if (i == 30) rx_drv = 1'b1;
            tick();
            if (bus.byte_available) np++;
        end
        chk("glitch no pulse", np, 0);
        chk("glitch rx_byte kept", bus.rx_byte, 8'h3C);

        // Framing error, then a good frame to show recovery.
        send_rx(8'h55, 1'b0, 300, np, at, val);
        chk("frame err no pulse", np, 0);
        chk("frame err rx_byte kept", bus.rx_byte, 8'h3C);
        send_rx(8'h81, 1'b1, 20, np, at, val);
        chk("rx 81 pulses", np, 1);
        chk("rx 81 value", val, 8'h81);

        // Reset clears the received byte.
        rst_n = 1'b0;
        tick();
        chk("reset clears rx_byte", bus.rx_byte, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Loopback: 0x00, 0xFF, 0x5A back-to-back.
        loop_en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.tx_byte      = 8'h00;
        bus.send_request = 1'b1;
        tick();
        np   = 0;
        flag = 1'b0;
        got  = '{8'h00, 8'h00, 8'h00};
        for (int j = 0; j < 3300; j++) begin
            if (j == 0) bus.tx_byte = 8'hFF;
            if (j == 1040) begin
                bus.tx_byte = 8'h5A;
                chk("b2b frame 2 start bit", tx, 0);
            end
            if (j == 2080) begin
                bus.send_request = 1'b0;
                chk("b2b frame 3 start bit", tx, 0);
            end
            if (j < 3120 && !bus.busy) flag = 1'b1;
            if (j == 3120) chk("loopback busy falls", bus.busy, 0);
            tick();
            if (bus.byte_available) begin
                if (np < 3) got[np] = bus.rx_byte;
                np++;
            end
        end
        chk("loopback no idle gap", flag, 0);
        chk("loopback pulses", np, 3);
        chk("loopback byte0", got[0], 8'h00);
        chk("loopback byte1", got[1], 8'hFF);
        chk("loopback byte2", got[2], 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
